// File: rtl/sub_pkg.sv
// Shared definitions for serial_subtractor: FSM state encoding and the
// parameter sanity check used at elaboration.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit digit_ok(input int width, input int digit);
    return (width >= 2) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor cell: d = x - y - br, with borrow out.
module full_sub (
  input  logic i_x,
  input  logic i_y,
  input  logic i_br,
  output logic o_d,
  output logic o_br
);

  assign o_d  = i_x ^ i_y ^ i_br;
  assign o_br = (~i_x & i_y) | (~(i_x ^ i_y) & i_br);

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per clock,
// valid/ready on both sides. Define SERIAL_SUB_SAT_EN to clamp underflow to zero.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  generate
    if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_param
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic [CW-1:0]    r_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_last;
  logic [DIGIT-1:0] w_d;
  logic [DIGIT:0]   w_br;
  logic [WIDTH-1:0] w_diff_nxt;

  // Borrow ripples through DIGIT cells starting from the held borrow.
  assign w_br[0] = r_br;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_cell
      full_sub u_cell (
        .i_x  (r_a[gi]),
        .i_y  (r_b[gi]),
        .i_br (w_br[gi]),
        .o_d  (w_d[gi]),
        .o_br (w_br[gi+1])
      );
    end

    if (DIGIT == WIDTH) begin : g_diff_full
      assign w_diff_nxt = w_d;
    end else begin : g_diff_shift
      assign w_diff_nxt = {w_d, r_diff[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign w_last = (r_cnt == CW'(STEPS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = CALC;
      end
      CALC: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_in_ready = out_ready;
        if (out_ready) w_state_nxt = in_valid ? CALC : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_accept = in_valid & w_in_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= bin;
      r_cnt <= '0;
    end else if (r_state == CALC) begin
      r_a    <= r_a >> DIGIT;
      r_b    <= r_b >> DIGIT;
      r_br   <= w_br[DIGIT];
      r_cnt  <= r_cnt + 1'b1;
      r_diff <= w_diff_nxt;
`ifdef SERIAL_SUB_SAT_EN
      // Underflow clamps to zero; bout still reports the borrow.
      if (w_last && w_br[DIGIT]) r_diff <= '0;
`endif
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == CALC);
  assign diff      = r_diff;
  assign bout      = r_br;

endmodule
